// File: rtl/wb_result_arbiter.sv
// Round-robin writeback arbiter: one-hot grant gating, wide OR merge and a
// 1-entry registered output buffer feeding the register-file write port.

module large_fan_in_or #(
    parameter int WIDTH       = 32,
    parameter int OR_QUANTITY = 4
) (
    input  logic [WIDTH*OR_QUANTITY-1:0] data_in,
    output logic [WIDTH-1:0]             data_out
);
    always_comb begin
        data_out = '0;
        for (int i = 0; i < OR_QUANTITY; i++) begin
            data_out = data_out | data_in[i*WIDTH +: WIDTH];
        end
    end
endmodule

// One source's AND stage: non-granted units contribute zero to the merge.
module wb_src_gate #(
    parameter int WIDTH    = 32,
    parameter int RD_WIDTH = 5
) (
    input  logic                grant,
    input  logic [WIDTH-1:0]    data,
    input  logic [RD_WIDTH-1:0] rd,
    output logic [WIDTH-1:0]    data_gated,
    output logic [RD_WIDTH-1:0] rd_gated
);
    assign data_gated = data & {WIDTH{grant}};
    assign rd_gated   = rd & {RD_WIDTH{grant}};
endmodule

module wb_result_arbiter #(
    parameter int WIDTH        = 32,
    parameter int SRC_QUANTITY = 4,
    parameter int RD_WIDTH     = 5
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [SRC_QUANTITY-1:0]          src_valid,
    output logic [SRC_QUANTITY-1:0]          src_ready,
    input  logic [WIDTH*SRC_QUANTITY-1:0]    src_data,
    input  logic [RD_WIDTH*SRC_QUANTITY-1:0] src_rd,
    output logic                             wb_valid,
    input  logic                             wb_ready,
    output logic [WIDTH-1:0]                 wb_data,
    output logic [RD_WIDTH-1:0]              wb_rd,
    output logic [SRC_QUANTITY-1:0]          wb_src
);
    localparam int PW = (SRC_QUANTITY > 1) ? $clog2(SRC_QUANTITY) : 1;

    logic [PW-1:0]                    ptr_q, ptr_d, nxt_ptr;
    logic                             wb_valid_q, wb_valid_d;
    logic [WIDTH-1:0]                 wb_data_q, wb_data_d;
    logic [RD_WIDTH-1:0]              wb_rd_q, wb_rd_d;
    logic [SRC_QUANTITY-1:0]          wb_src_q, wb_src_d;
    logic [SRC_QUANTITY-1:0]          grant;
    logic                             can_load, xfer;
    logic [WIDTH*SRC_QUANTITY-1:0]    data_gated;
    logic [RD_WIDTH*SRC_QUANTITY-1:0] rd_gated;
    logic [WIDTH-1:0]                 merged_data;
    logic [RD_WIDTH-1:0]              merged_rd;

    assign can_load = !wb_valid_q || wb_ready;

    // Scan from ptr with wrap; first valid unit wins.
    always_comb begin
        int   idx;
        logic found;
        idx     = 0;
        found   = 1'b0;
        grant   = '0;
        nxt_ptr = ptr_q;
        for (int k = 0; k < SRC_QUANTITY; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= SRC_QUANTITY) idx = idx - SRC_QUANTITY;
            if (can_load && !found && src_valid[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                nxt_ptr    = (idx + 1 == SRC_QUANTITY) ? '0 : PW'(idx + 1);
            end
        end
    end

    // A single source is a plain pipeline register: ready tracks buffer space.
    assign src_ready = (SRC_QUANTITY == 1) ? {SRC_QUANTITY{can_load}} : grant;
    assign xfer      = |(src_valid & src_ready);

    for (genvar i = 0; i < SRC_QUANTITY; i++) begin : g_gate
        wb_src_gate #(.WIDTH(WIDTH), .RD_WIDTH(RD_WIDTH)) u_gate (
            .grant      (grant[i]),
            .data       (src_data[i*WIDTH +: WIDTH]),
            .rd         (src_rd[i*RD_WIDTH +: RD_WIDTH]),
            .data_gated (data_gated[i*WIDTH +: WIDTH]),
            .rd_gated   (rd_gated[i*RD_WIDTH +: RD_WIDTH])
        );
    end

    large_fan_in_or #(.WIDTH(WIDTH), .OR_QUANTITY(SRC_QUANTITY)) u_or_data (
        .data_in  (data_gated),
        .data_out (merged_data)
    );

    large_fan_in_or #(.WIDTH(RD_WIDTH), .OR_QUANTITY(SRC_QUANTITY)) u_or_rd (
        .data_in  (rd_gated),
        .data_out (merged_rd)
    );

    always_comb begin
        ptr_d      = ptr_q;
        wb_valid_d = wb_valid_q;
        wb_data_d  = wb_data_q;
        wb_rd_d    = wb_rd_q;
        wb_src_d   = wb_src_q;
        if (xfer) begin
            ptr_d      = nxt_ptr;
            wb_valid_d = 1'b1;
            wb_data_d  = merged_data;
            wb_rd_d    = merged_rd;
            wb_src_d   = grant;
        end else if (wb_ready) begin
            wb_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q      <= '0;
            wb_valid_q <= 1'b0;
            wb_data_q  <= '0;
            wb_rd_q    <= '0;
            wb_src_q   <= '0;
        end else begin
            ptr_q      <= ptr_d;
            wb_valid_q <= wb_valid_d;
            wb_data_q  <= wb_data_d;
            wb_rd_q    <= wb_rd_d;
            wb_src_q   <= wb_src_d;
        end
    end

    assign wb_valid = wb_valid_q;
    assign wb_data  = wb_data_q;
    assign wb_rd    = wb_rd_q;
    assign wb_src   = wb_src_q;
endmodule

// File: tb/tb_wb_result_arbiter.sv
// Directed bench: round-robin table for a 4-source build plus corner sequences
// and an in-order stream through a single-source build.

module tb_wb_result_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic [3:0]   src_valid = '0;
    logic [3:0]   src_ready;
    logic [127:0] src_data;
    logic [19:0]  src_rd;
    logic         wb_valid;
    logic         wb_ready = 1'b0;
    logic [31:0]  wb_data;
    logic [4:0]   wb_rd;
    logic [3:0]   wb_src;

    logic [31:0] drv_data [4];
    logic [4:0]  drv_rd   [4];

    logic [0:0]  src_valid1 = '0;
    logic [0:0]  src_ready1;
    logic [31:0] src_data1 = '0;
    logic [4:0]  src_rd1 = '0;
    logic        wb_valid1;
    logic        wb_ready1 = 1'b0;
    logic [31:0] wb_data1;
    logic [4:0]  wb_rd1;
    logic [0:0]  wb_src1;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            src_data[i*32 +: 32] = drv_data[i];
            src_rd[i*5 +: 5]     = drv_rd[i];
        end
    end

    wb_result_arbiter #(.WIDTH(32), .SRC_QUANTITY(4), .RD_WIDTH(5)) dut (
        .clk(clk), .rst(rst), .src_valid(src_valid), .src_ready(src_ready),
        .src_data(src_data), .src_rd(src_rd), .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_data(wb_data), .wb_rd(wb_rd), .wb_src(wb_src)
    );

    wb_result_arbiter #(.WIDTH(32), .SRC_QUANTITY(1), .RD_WIDTH(5)) dut1 (
        .clk(clk), .rst(rst), .src_valid(src_valid1), .src_ready(src_ready1),
        .src_data(src_data1), .src_rd(src_rd1), .wb_valid(wb_valid1), .wb_ready(wb_ready1),
        .wb_data(wb_data1), .wb_rd(wb_rd1), .wb_src(wb_src1)
    );

    typedef struct {
        logic [3:0] valid;
        logic       rdy;
        logic [3:0] exp_ready;
        logic       exp_v;
        logic [3:0] exp_src;
    } vec_t;

    vec_t tbl [18];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] base_data(input int i);
        return 32'h1111_0000 * (i + 1) + i;
    endfunction

    function automatic void load_base();
        for (int i = 0; i < 4; i++) begin
            drv_data[i] = base_data(i);
            drv_rd[i]   = 5'(10 + i);
        end
    endfunction

    // Drive at posedge+1, check src_ready at negedge, buffer at next posedge+1.
    task automatic step(input string nm, input logic [3:0] v, input logic r,
                        input logic [3:0] er, input logic ev, input logic [31:0] ed,
                        input logic [4:0] erd, input logic [3:0] es);
        src_valid = v;
        wb_ready  = r;
        @(negedge clk);
        chk({nm, " src_ready"}, 32'(src_ready), 32'(er));
        @(posedge clk);
        #1;
        chk({nm, " wb_valid"}, 32'(wb_valid), 32'(ev));
        chk({nm, " wb_data"}, wb_data, ed);
        chk({nm, " wb_rd"}, 32'(wb_rd), 32'(erd));
        chk({nm, " wb_src"}, 32'(wb_src), 32'(es));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int sent, recv, cyc;
        logic [31:0] ed;
        logic [4:0]  erd;
        logic [3:0]  es;

        load_base();
        tbl[0]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 4'b0001};
        tbl[1]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 4'b0010};
        tbl[2]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 4'b0100};
        tbl[3]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 4'b1000};
        tbl[4]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 4'b0001};
        tbl[5]  = '{4'b1111, 1'b0, 4'b0000, 1'b1, 4'b0001};
        tbl[6]  = '{4'b1111, 1'b0, 4'b0000, 1'b1, 4'b0001};
        tbl[7]  = '{4'b1111, 1'b0, 4'b0000, 1'b1, 4'b0001};
        tbl[8]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 4'b0010};
        tbl[9]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 4'b0010};
        tbl[10] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0010};
        tbl[11] = '{4'b1001, 1'b0, 4'b1000, 1'b1, 4'b1000};
        tbl[12] = '{4'b1001, 1'b0, 4'b0000, 1'b1, 4'b1000};
        tbl[13] = '{4'b1001, 1'b1, 4'b0001, 1'b1, 4'b0001};
        tbl[14] = '{4'b1000, 1'b1, 4'b1000, 1'b1, 4'b1000};
        tbl[15] = '{4'b0100, 1'b1, 4'b0100, 1'b1, 4'b0100};
        tbl[16] = '{4'b0011, 1'b1, 4'b0001, 1'b1, 4'b0001};
        tbl[17] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 4'b0001};

        // Reset state
        do_reset();
        chk("reset wb_valid", 32'(wb_valid), 32'd0);
        chk("reset wb_data", wb_data, 32'd0);
        chk("reset wb_rd", 32'(wb_rd), 32'd0);
        chk("reset wb_src", 32'(wb_src), 32'd0);

        // Unit2 alone
        drv_data[2] = 32'hDEAD_BEEF;
        drv_rd[2]   = 5'd7;
        step("unit2 alone", 4'b0100, 1'b1, 4'b0100, 1'b1, 32'hDEAD_BEEF, 5'd7, 4'b0100);
        src_valid = '0;

        // Round-robin table from ptr=0
        load_base();
        do_reset();
        for (int n = 0; n < 18; n++) begin
            ed = 32'd0; erd = 5'd0; es = tbl[n].exp_src;
            for (int i = 0; i < 4; i++)
                if (es[i]) begin ed = base_data(i); erd = 5'(10 + i); end
            step($sformatf("vec%0d", n), tbl[n].valid, tbl[n].rdy, tbl[n].exp_ready,
                 tbl[n].exp_v, ed, erd, es);
        end

        // Push ptr to 3, then unit1 (all ones) vs unit3 (0xFF, rd=0)
        step("ptr to 3", 4'b0100, 1'b1, 4'b0100, 1'b1, base_data(2), 5'd12, 4'b0100);
        drv_data[1] = 32'hFFFF_FFFF; drv_rd[1] = 5'd31;
        drv_data[3] = 32'h0000_00FF; drv_rd[3] = 5'd0;
        step("no leak", 4'b1010, 1'b1, 4'b1000, 1'b1, 32'h0000_00FF, 5'd0, 4'b1000);

        // Async reset with full buffer and a pending request
        src_valid = 4'b1010;
        wb_ready  = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("midreset wb_valid", 32'(wb_valid), 32'd0);
        chk("midreset wb_data", wb_data, 32'd0);
        chk("midreset wb_src", 32'(wb_src), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("postreset src_ready", 32'(src_ready), 32'b0010);
        @(posedge clk);
        #1;
        chk("postreset wb_src", 32'(wb_src), 32'b0010);
        chk("postreset wb_data", wb_data, 32'hFFFF_FFFF);
        src_valid = '0;

        // Single-source stream with random stalls
        sent = 0; recv = 0; cyc = 0;
        while (recv < 10 && cyc < 300) begin
            src_valid1 = (sent < 10) ? 1'($urandom_range(0, 3) != 0) : 1'b0;
            src_data1  = 32'hC0DE_0000 + 32'(sent);
            src_rd1    = 5'(sent + 1);
            wb_ready1  = 1'($urandom_range(0, 2) != 0);
            @(negedge clk);
            if (wb_valid1 && wb_ready1) begin
                chk("stream data", wb_data1, 32'hC0DE_0000 + 32'(recv));
                chk("stream rd", 32'(wb_rd1), 32'(5'(recv + 1)));
                recv++;
            end
            if (src_valid1[0] && src_ready1[0]) sent++;
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("stream count", 32'(recv), 32'd10);
        chk("stream sent", 32'(sent), 32'd10);
        src_valid1 = '0;
        wb_ready1  = 1'b1;
        @(posedge clk);
        #1;
        chk("stream drained", 32'(wb_valid1), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
